updown_counter: RTL

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter_if.sv | 29 ++
 rtl/updown_counter.sv | 90 +++++++++
 2 files changed

// File: rtl/updown_counter_if.sv
// Bus bundle for updown_counter: control requests in, count and status flags out.
// The counter connects to the slave side; whoever drives the requests uses master.
interface updown_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             increment;
    logic             decrement;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             sat_mode;
    logic             clear_flags;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             overflow;
    logic             underflow;
    logic             wrap_pulse;

    modport master (
        output enable, increment, decrement, load, load_value, sat_mode, clear_flags,
        input  count, at_max, at_min, overflow, underflow, wrap_pulse
    );

    modport slave (
        input  enable, increment, decrement, load, load_value, sat_mode, clear_flags,
        output count, at_max, at_min, overflow, underflow, wrap_pulse
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter with upper limit MAX_VAL, step STEP, wrap or saturate at the limits,
// sticky overflow/underflow flags and a one-cycle pulse after each wrap.
module updown_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned  STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    updown_counter_if.slave    bus
);
    // One extra bit so count+STEP and count+MAX_VAL+1 never truncate before comparison.
    localparam int unsigned     EW       = WIDTH + 1;
    localparam logic [EW-1:0]   MAX_EXT  = EW'(MAX_VAL);
    localparam logic [EW-1:0]   WRAP_EXT = EW'(MAX_VAL + 64'd1);
    localparam logic [EW-1:0]   STEP_EXT = EW'(STEP);

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_wrap_pulse;

    logic [EW-1:0]    w_count_ext;
    logic [EW-1:0]    w_load_ext;
    logic [EW-1:0]    w_sum;
    logic             w_inc_req;
    logic             w_dec_req;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [WIDTH-1:0] w_count_next;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_ext  = {1'b0, r_count};
        w_load_ext   = {1'b0, bus.load_value};
        w_sum        = w_count_ext + STEP_EXT;
        w_inc_req    = bus.enable && bus.increment && !bus.decrement && !bus.load;
        w_dec_req    = bus.enable && bus.decrement && !bus.increment && !bus.load;
        w_ovf_evt    = w_inc_req && (w_sum > MAX_EXT);
        w_udf_evt    = w_dec_req && (w_count_ext < STEP_EXT);
        w_count_next = r_count;

        if (bus.load) begin
            w_count_next = (w_load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : bus.load_value;
        end else if (w_inc_req) begin
            if (!w_ovf_evt)
                w_count_next = WIDTH'(w_sum);
            else if (bus.sat_mode)
                w_count_next = WIDTH'(MAX_EXT);
            else
                w_count_next = WIDTH'(w_sum - WRAP_EXT);
        end else if (w_dec_req) begin
            if (!w_udf_evt)
                w_count_next = WIDTH'(w_count_ext - STEP_EXT);
            else if (bus.sat_mode)
                w_count_next = '0;
            else
                w_count_next = WIDTH'(w_count_ext + WRAP_EXT - STEP_EXT);
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_wrap_pulse <= (w_ovf_evt || w_udf_evt) && !bus.sat_mode;
            // A limit crossing on the same edge beats clear_flags.
            if (w_ovf_evt)
                r_overflow <= 1'b1;
            else if (bus.clear_flags)
                r_overflow <= 1'b0;
            if (w_udf_evt)
                r_underflow <= 1'b1;
            else if (bus.clear_flags)
                r_underflow <= 1'b0;
        end
    end

    assign bus.count      = r_count;
    assign bus.at_max     = (r_count == WIDTH'(MAX_EXT));
    assign bus.at_min     = (r_count == '0);
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
    assign bus.wrap_pulse = r_wrap_pulse;
endmodule
